// File: rtl/bus_xbar_rd.sv
// One-master to N_SLAVES read/write crossbar with address-field slave decode,
// a single outstanding read, and error responses for unmapped addresses or timeouts.

module bus_xbar_port #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          rd_hit,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_hit,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          s_rd_en,
  output logic [AW-1:0] s_rd_addr,
  output logic          s_wr_en,
  output logic [AW-1:0] s_wr_addr,
  output logic [DW-1:0] s_wr_data
);
  // Unselected ports are driven to all-zero, not just de-strobed.
  assign s_rd_en   = rd_hit;
  assign s_rd_addr = rd_hit ? rd_addr : '0;
  assign s_wr_en   = wr_hit;
  assign s_wr_addr = wr_hit ? wr_addr : '0;
  assign s_wr_data = wr_hit ? wr_data : '0;
endmodule

module bus_xbar_rd #(
  parameter int              N_SLAVES = 2,
  parameter int              AW       = 16,
  parameter int              DW       = 32,
  parameter int              SEL_LSB  = 12,
  parameter int              TIMEOUT  = 15,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  output logic [DW-1:0]          rd_data,
  output logic                   rd_valid,
  output logic                   rd_err,
  output logic                   rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_err,
  output logic [N_SLAVES-1:0]    s_rd_en,
  output logic [N_SLAVES*AW-1:0] s_rd_addr,
  input  logic [N_SLAVES*DW-1:0] s_rd_data,
  input  logic [N_SLAVES-1:0]    s_rd_valid,
  output logic [N_SLAVES-1:0]    s_wr_en,
  output logic [N_SLAVES*AW-1:0] s_wr_addr,
  output logic [N_SLAVES*DW-1:0] s_wr_data
);
  localparam int             SW   = AW - SEL_LSB;
  localparam int             SLW  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [SW:0]    NS   = (SW+1)'(N_SLAVES);
  localparam logic [7:0]     TMAX = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state, state_nxt;
  logic [SLW-1:0]   sel, sel_nxt;
  logic [7:0]       timer, timer_nxt;
  logic             rv_nxt, rerr_nxt, werr_nxt;
  logic [DW-1:0]    rdata_nxt;

  logic [SW-1:0]    rd_idx, wr_idx;
  logic             rd_map, wr_map;
  logic [AW-1:0]    rd_addr_t, wr_addr_t;
  logic [N_SLAVES-1:0] rd_hit, wr_hit;
  logic [N_SLAVES-1:0][DW-1:0] rdata_arr;

  assign rd_idx    = rd_addr[AW-1:SEL_LSB];
  assign wr_idx    = wr_addr[AW-1:SEL_LSB];
  assign rd_map    = {1'b0, rd_idx} < NS;
  assign wr_map    = {1'b0, wr_idx} < NS;
  assign rd_addr_t = {{SW{1'b0}}, rd_addr[SEL_LSB-1:0]};
  assign wr_addr_t = {{SW{1'b0}}, wr_addr[SEL_LSB-1:0]};
  assign rdata_arr = s_rd_data;
  assign rd_busy   = (state == WAIT);

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_SLAVES; i++)
      wr_hit[i] = wr_en && (wr_idx == SW'(i));
  end

  bus_xbar_port #(.AW(AW), .DW(DW)) u_port [N_SLAVES-1:0] (
    .rd_hit    (rd_hit),
    .rd_addr   (rd_addr_t),
    .wr_hit    (wr_hit),
    .wr_addr   (wr_addr_t),
    .wr_data   (wr_data),
    .s_rd_en   (s_rd_en),
    .s_rd_addr (s_rd_addr),
    .s_wr_en   (s_wr_en),
    .s_wr_addr (s_wr_addr),
    .s_wr_data (s_wr_data)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    timer_nxt = timer;
    rv_nxt    = 1'b0;
    rerr_nxt  = 1'b0;
    rdata_nxt = rd_data;
    werr_nxt  = wr_en && !wr_map;
    rd_hit    = '0;
    case (state)
      IDLE: begin
        if (rd_en && rd_map) begin
          for (int i = 0; i < N_SLAVES; i++)
            rd_hit[i] = (rd_idx == SW'(i));
          sel_nxt   = rd_idx[SLW-1:0];
          timer_nxt = '0;
          state_nxt = WAIT;
        end else if (rd_en) begin
          rv_nxt    = 1'b1;
          rerr_nxt  = 1'b1;
          rdata_nxt = ERR_DATA;
        end
      end
      WAIT: begin
        // Valid beats timeout when both land in the same cycle.
        if (s_rd_valid[sel]) begin
          rv_nxt    = 1'b1;
          rdata_nxt = rdata_arr[sel];
          state_nxt = IDLE;
        end else if (timer == TMAX) begin
          rv_nxt    = 1'b1;
          rerr_nxt  = 1'b1;
          rdata_nxt = ERR_DATA;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      sel      <= '0;
      timer    <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      timer    <= timer_nxt;
      rd_valid <= rv_nxt;
      rd_err   <= rerr_nxt;
      rd_data  <= rdata_nxt;
      wr_err   <= werr_nxt;
    end
  end
endmodule

// File: tb/tb_bus_xbar_rd.sv
// Directed bench for bus_xbar_rd: 1-cycle ram at slave 0, scripted slave 1.

module tb_bus_xbar_rd;
  localparam int AW = 16, DW = 32, NS = 2;

  logic            clk = 1'b0, rstn = 1'b0;
  logic            rd_en = 1'b0, wr_en = 1'b0;
  logic [AW-1:0]   rd_addr = '0, wr_addr = '0;
  logic [DW-1:0]   wr_data = '0, rd_data;
  logic            rd_valid, rd_err, rd_busy, wr_err;
  logic [NS-1:0]   s_rd_en, s_rd_valid, s_wr_en;
  logic [NS*AW-1:0] s_rd_addr, s_wr_addr;
  logic [NS*DW-1:0] s_rd_data, s_wr_data;

  logic [DW-1:0]   mem [16];
  logic            ram_v = 1'b0, inj0 = 1'b0, s1_v = 1'b0, s0_seen = 1'b0;
  logic [DW-1:0]   ram_d = '0, s1_d = '0;
  bit              quiet;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign s_rd_valid = {s1_v, ram_v | inj0};
  assign s_rd_data  = {s1_d, ram_d};

  always @(posedge clk) begin
    ram_v <= s_rd_en[0];
    ram_d <= mem[s_rd_addr[5:2]];
    if (s_rd_en[0]) s0_seen <= 1'b1;
  end

  bus_xbar_rd dut (
    .clk(clk), .rstn(rstn),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
    .s_rd_valid(s_rd_valid), .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;

    // reset
    tick(); tick();
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_err",   rd_err,   0);
    chk("rst_data",  rd_data,  0);
    chk("rst_busy",  rd_busy,  0);
    chk("rst_werr",  wr_err,   0);
    rstn = 1'b1;

    // read slave 0 (ram)
    tick(); rd_en = 1'b1; rd_addr = 16'h0008; #1;
    chk("t1_s_rd_en", s_rd_en, 2'b01);
    chk("t1_s_addr0", s_rd_addr[AW-1:0], 16'h0008);
    chk("t1_busy0",   rd_busy, 0);
    tick(); rd_en = 1'b0; #1;
    chk("t1_busy1",   rd_busy, 1);
    chk("t1_v_early", rd_valid, 0);
    tick(); #1;
    chk("t1_valid",   rd_valid, 1);
    chk("t1_err",     rd_err, 0);
    chk("t1_data",    rd_data, 32'hA5A5_0002);
    chk("t1_busy2",   rd_busy, 0);

    // read slave 1, 3-cycle response
    s0_seen = 1'b0;
    tick(); rd_en = 1'b1; rd_addr = 16'h1000; #1;
    chk("t2_s_rd_en", s_rd_en, 2'b10);
    chk("t2_s_addr1", s_rd_addr[2*AW-1:AW], 16'h0000);
    tick(); rd_en = 1'b0;
    tick();
    tick(); s1_v = 1'b1; s1_d = 32'h5; #1;
    chk("t2_v_early", rd_valid, 0);
    tick(); s1_v = 1'b0; #1;
    chk("t2_valid",   rd_valid, 1);
    chk("t2_err",     rd_err, 0);
    chk("t2_data",    rd_data, 32'h5);
    chk("t2_s0_idle", s0_seen, 0);

    // unmapped read and write, plus a mapped write
    tick(); rd_en = 1'b1; rd_addr = 16'h3004;
    wr_en = 1'b1; wr_addr = 16'h3004; wr_data = 32'h1111_2222; #1;
    chk("t3_no_rd",   s_rd_en, 2'b00);
    chk("t3_no_wr",   s_wr_en, 2'b00);
    tick(); rd_en = 1'b0; wr_addr = 16'h1010; wr_data = 32'h0000_1234; #1;
    chk("t3_valid",   rd_valid, 1);
    chk("t3_err",     rd_err, 1);
    chk("t3_data",    rd_data, 32'hDEAD_BEEF);
    chk("t3_werr",    wr_err, 1);
    chk("t3_busy",    rd_busy, 0);
    chk("t3_wr_en",   s_wr_en, 2'b10);
    chk("t3_wr_addr", s_wr_addr, {16'h0010, 16'h0000});
    chk("t3_wr_data", s_wr_data, {32'h0000_1234, 32'h0});
    tick(); wr_en = 1'b0; #1;
    chk("t3_v_pulse", rd_valid, 0);
    chk("t3_werr_ok", wr_err, 0);
    chk("t3_hold",    rd_data, 32'hDEAD_BEEF);

    // timeout on slave 1, with stray slave-0 valid and a dropped rd_en
    tick(); rd_en = 1'b1; rd_addr = 16'h1000;
    quiet = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      rd_en = (k == 3);
      rd_addr = 16'h0000;
      inj0 = (k == 5);
      #1;
      if (rd_valid !== 1'b0 || rd_busy !== 1'b1) quiet = 1'b0;
      if (k == 3) chk("t4_drop_rd", s_rd_en, 2'b00);
    end
    rd_en = 1'b0; inj0 = 1'b0;
    chk("t4_quiet",   quiet, 1);
    tick(); #1;
    chk("t4_valid",   rd_valid, 1);
    chk("t4_err",     rd_err, 1);
    chk("t4_data",    rd_data, 32'hDEAD_BEEF);

    // valid collides with timeout: valid wins
    tick(); rd_en = 1'b1; rd_addr = 16'h1000;
    for (int k = 1; k <= 15; k++) begin
      tick();
      rd_en = 1'b0;
      s1_v = (k == 15);
      s1_d = 32'h77;
    end
    tick(); s1_v = 1'b0; #1;
    chk("t5_valid",   rd_valid, 1);
    chk("t5_err",     rd_err, 0);
    chk("t5_data",    rd_data, 32'h77);

    // reset during WAIT
    tick(); rd_en = 1'b1; rd_addr = 16'h1000;
    tick(); rd_en = 1'b0; rstn = 1'b0;
    tick(); rstn = 1'b1; #1;
    chk("t6_busy",    rd_busy, 0);
    chk("t6_valid",   rd_valid, 0);
    chk("t6_data",    rd_data, 0);
    chk("t6_err",     rd_err, 0);
    tick(); s1_v = 1'b1; s1_d = 32'h99;
    tick(); s1_v = 1'b0; #1;
    chk("t6_late_v",  rd_valid, 0);
    chk("t6_late_d",  rd_data, 0);
    tick(); rd_en = 1'b1; rd_addr = 16'h0008;
    tick(); rd_en = 1'b0;
    tick(); #1;
    chk("t6_valid2",  rd_valid, 1);
    chk("t6_data2",   rd_data, 32'hA5A5_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
